sdram_burst_writer: RTL
=======================

# sdram_burst_writer

Parametrised drain engine between a read-side FIFO and the SDRAM write port, running entirely in the SDRAM clock domain. It pulls fixed-length bursts of BURST_LEN words from the FIFO and presents them as write beats with a linearly incrementing word address. It adds three capabilities:
- partial-burst flush with padding, so no data is stranded;
- a wrapping address window;
- an explicit end-of-transfer pulse after a long idle period.

## Interface
Parameters:
- DATA_W, 16: FIFO and SDRAM word width.
- ADDR_W, 24: SDRAM word-address width.
- LVL_W, 10: width of the FIFO fill-level input.
- BURST_LEN, 8: beats per burst. Power of two, 2 to 256.
- ARM_CLKS, 63: maximum wait for the FIFO to fill before a partial flush.
- TIMEOUT_CLKS, 133000000: idle cycles that mark the end of a transfer.
- ADDR_BASE, 0: first address of the write window.
- ADDR_TOP, 24'hFFFFFF: last address of the window. (ADDR_TOP−ADDR_BASE+1) must be a multiple of BURST_LEN.
- PAD_WORD, 0: data value driven on padded beats.

Ports:
- sdram_clk, in, 1: single clock.
- rst_n, in, 1: reset, synchronous, active-low.
- fifo_ren, out, 1: FIFO read strobe. Data appears one cycle later.
- fifo_rdata, in, DATA_W: FIFO read data.
- fifo_rempty, in, 1: FIFO empty flag.
- fifo_rlevel, in, LVL_W: FIFO fill level, in words.
- wr_data, out, DATA_W: beat data.
- wr_addr, out, ADDR_W: beat word address.
- wr_valid, out, 1: beat present this cycle.
- wr_last, out, 1: final beat of the burst.
- wr_pad, out, 1: beat is padding. The sink must mask it (DQM).
- wr_ready, in, 1: sink credit. High in cycle N guarantees acceptance of a beat presented in cycle N+1.
- xfer_done, out, 1: one-cycle pulse at idle timeout.
- wrap_pulse, out, 1: one-cycle pulse when the address wraps.

## Operation
States:
- IDLE
  - If wr_ready and fifo_rlevel ≥ BURST_LEN: go to BURST.
  - Else if wr_ready and not fifo_rempty: go to ARM.
- ARM
  - Counts up to ARM_CLKS.
  - If fifo_rlevel ≥ BURST_LEN: go to BURST immediately.
  - When the count reaches ARM_CLKS: go to BURST as a partial burst.
  - On entry to BURST, latch n_words = min(fifo_rlevel, BURST_LEN). n_words is never 0, because the FIFO is non-empty in ARM.
- BURST
  - fifo_ren = !fifo_rempty && wr_ready && (rd_cnt < n_words).
  - rd_cnt increments on each fifo_ren.
  - When rd_cnt reaches n_words:
    - if n_words == BURST_LEN, go to GAP;
    - otherwise go to PAD.
- PAD
  - Issues one padded beat per cycle in which wr_ready is high, until the total beat count reaches BURST_LEN. Then go to GAP.
- GAP
  - One cycle, to let the last beat drain.
  - Then go to BURST if fifo_rlevel ≥ BURST_LEN and wr_ready; otherwise go to IDLE.

Beat rules:
- A beat counter counts both real and padded beats. wr_last is asserted on beat BURST_LEN−1.
- wr_data is registered from fifo_rdata for real beats and is PAD_WORD for padded beats.

Address rules:
- wr_addr changes only on a beat (wr_valid && wr_ready). On a beat it increments by 1.
- At ADDR_TOP it wraps to ADDR_BASE and pulses wrap_pulse.

Idle timeout:
- A saturating idle counter increments in IDLE and clears in every other state.
- When it reaches TIMEOUT_CLKS: wr_addr is set to ADDR_BASE and xfer_done pulses once. The pulse does not repeat until the FSM has left IDLE.

## Timing
- Reset: state IDLE and all counters 0. fifo_ren, wr_valid, wr_last, wr_pad, xfer_done, wrap_pulse are 0. wr_data is 0. wr_addr is ADDR_BASE.
- Latency: fifo_ren or a pad issue in cycle N produces wr_valid, wr_data, wr_last and wr_pad in cycle N+1. wr_valid is registered.
- If wr_ready drops mid-burst, issue pauses with no beat lost. The beat already scheduled for N+1 is still presented; the sink honours its credit.
- If fifo_rempty rises mid-burst (FIFO underrun, which only occurs because the level input lags): reads stall and the FSM stays in BURST. It never pads in this case, because n_words has already been promised.
- Beats that cross the wrap boundary within one burst cannot occur, given the alignment constraint on the window.
- A timeout and a beat cannot fire together, because a beat never occurs in IDLE.
- rst_n asserted mid-burst aborts the burst on the next edge. No pulse outputs fire.
- Minimum burst-to-burst spacing is BURST_LEN + 1 cycles.

## Structure
- Shared package sdram_wr_pkg holds:
  - the state enum (IDLE, ARM, BURST, PAD, GAP);
  - the state-width constant;
  - a counter-width helper built on $clog2(BURST_LEN+1).
- Natural sub-module: sdram_addr_window. It holds the wr_addr register, increment, wrap at ADDR_TOP, timeout clear, and wrap_pulse.
- The FSM, counters and output registers live in the top module.

## Test plan
- BURST_LEN=8, FIFO preloaded with 8 words 0x0001..0x0008, wr_ready held 1: exactly 8 fifo_ren pulses; beats 0x0001..0x0008 at addresses 0..7; wr_last on address 7; wr_pad never set.
- 3 words 0xA0..0xA2 loaded, nothing more: after 63 ARM cycles, 3 real beats, then 5 beats with wr_pad=1 and data 0; wr_last on the 8th beat; next burst starts at address 8.
- Full burst with wr_ready toggling 1,0,1,0: 8 beats delivered in order; no duplicated or dropped data; each wr_valid occurs only in a cycle following wr_ready=1.
- ADDR_BASE=0x100, ADDR_TOP=0x10F, 24 words streamed: addresses 0x100..0x10F, then 0x100..0x107; wrap_pulse exactly once, on the beat at 0x10F.
- TIMEOUT_CLKS=20 after a burst ending at address 0x10: after 20 idle cycles, wr_addr becomes ADDR_BASE and xfer_done is a single one-cycle pulse; the next burst starts at ADDR_BASE.
- rst_n=0 for one cycle during beat 4: all outputs at reset values on the next edge; a fresh 8-word load then restarts at ADDR_BASE.

Source files
------------

// File: rtl/sdram_wr_pkg.sv
// Shared types and helpers for the SDRAM burst writer.
package sdram_wr_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StBurst = 3'd2,
    StPad   = 3'd3,
    StGap   = 3'd4
  } wr_state_e;

  // Width of a counter that must be able to hold the value burst_len itself.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/sdram_addr_window.sv
// Word-address register for the write port: steps on every presented beat,
// wraps from ADDR_TOP back to ADDR_BASE, and is forced to ADDR_BASE on timeout.
module sdram_addr_window
  import sdram_wr_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_TOP  = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap_pulse
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              at_top;

  assign at_top = (addr_q == ADDR_TOP);

  // Next address: a beat steps (or wraps); timeout rewinds. Both never coincide.
  always_comb begin
    addr_d = addr_q;
    if (beat) begin
      addr_d = at_top ? ADDR_BASE : addr_q + ADDR_W'(1);
    end else if (clear) begin
      addr_d = ADDR_BASE;
    end
  end

  // Address register with synchronous reset to the window base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= ADDR_BASE;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr       = addr_q;
  // Flags the beat that sits on the last window address.
  assign wrap_pulse = beat && at_top;

endmodule

// File: rtl/sdram_burst_writer.sv
// Drains a read-side FIFO into fixed-length SDRAM write bursts, padding short
// bursts after an arm timeout and signalling end-of-transfer after long idle.
module sdram_burst_writer
  import sdram_wr_pkg::*;
#(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       ADDR_W       = 24,
  parameter int unsigned       LVL_W        = 10,
  parameter int unsigned       BURST_LEN    = 8,
  parameter int unsigned       ARM_CLKS     = 63,
  parameter int unsigned       TIMEOUT_CLKS = 133000000,
  parameter logic [ADDR_W-1:0] ADDR_BASE    = '0,
  parameter logic [ADDR_W-1:0] ADDR_TOP     = '1,
  parameter logic [DATA_W-1:0] PAD_WORD     = '0
) (
  input  logic              sdram_clk,
  input  logic              rst_n,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rempty,
  input  logic [LVL_W-1:0]  fifo_rlevel,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  output logic              wr_last,
  output logic              wr_pad,
  input  logic              wr_ready,
  output logic              xfer_done,
  output logic              wrap_pulse
);

  localparam int unsigned CntW  = cnt_width(BURST_LEN);
  localparam int unsigned ArmW  = $clog2(ARM_CLKS + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CntW-1:0]  CntBurst = CntW'(BURST_LEN);
  localparam logic [CntW-1:0]  CntLast  = CntW'(BURST_LEN - 1);
  localparam logic [ArmW-1:0]  ArmLast  = ArmW'(ARM_CLKS - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CLKS - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_CLKS);
  localparam logic [LVL_W-1:0] LvlBurst = LVL_W'(BURST_LEN);

  wr_state_e        state_q, state_d;
  logic [CntW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CntW-1:0]  n_words_q, n_words_d;
  logic [ArmW-1:0]  arm_cnt_q, arm_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  logic wr_valid_q, wr_last_q, wr_pad_q, xfer_done_q;
  logic pad_issue, issue, level_full, timeout_fire;
  logic [CntW-1:0] lvl_words;

  assign level_full   = (fifo_rlevel >= LvlBurst);
  assign lvl_words    = level_full ? CntBurst : CntW'(fifo_rlevel);
  assign issue        = fifo_ren | pad_issue;
  assign timeout_fire = (state_q == StIdle) && (idle_cnt_q == IdleLast);

  // Next-state, read/pad issue and counter updates.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    n_words_d  = n_words_q;
    arm_cnt_d  = '0;
    idle_cnt_d = '0;
    fifo_ren   = 1'b0;
    pad_issue  = 1'b0;

    unique case (state_q)
      StIdle: begin
        rd_cnt_d   = '0;
        iss_cnt_d  = '0;
        idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
        if (wr_ready && level_full) begin
          state_d   = StBurst;
          n_words_d = CntBurst;
        end else if (wr_ready && !fifo_rempty) begin
          state_d = StArm;
        end
      end
      StArm: begin
        arm_cnt_d = arm_cnt_q + ArmW'(1);
        if (level_full || (arm_cnt_q == ArmLast)) begin
          state_d   = StBurst;
          n_words_d = lvl_words;
        end
      end
      StBurst: begin
        // An underrun only stalls here; the promised word count is never padded.
        fifo_ren = !fifo_rempty && wr_ready && (rd_cnt_q < n_words_q);
        if (fifo_ren) begin
          rd_cnt_d  = rd_cnt_q + CntW'(1);
          iss_cnt_d = iss_cnt_q + CntW'(1);
          if (rd_cnt_d == n_words_q) begin
            state_d = (n_words_q == CntBurst) ? StGap : StPad;
          end
        end
      end
      StPad: begin
        pad_issue = wr_ready;
        if (pad_issue) begin
          iss_cnt_d = iss_cnt_q + CntW'(1);
          if (iss_cnt_d == CntBurst) begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        rd_cnt_d  = '0;
        iss_cnt_d = '0;
        if (level_full && wr_ready) begin
          state_d   = StBurst;
          n_words_d = CntBurst;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge sdram_clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      n_words_q  <= '0;
      arm_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      n_words_q  <= n_words_d;
      arm_cnt_q  <= arm_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Beat qualifiers: an issue in cycle N becomes a presented beat in cycle N+1.
  always_ff @(posedge sdram_clk) begin
    if (!rst_n) begin
      wr_valid_q  <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_pad_q    <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      wr_valid_q  <= issue;
      wr_last_q   <= issue && (iss_cnt_q == CntLast);
      wr_pad_q    <= pad_issue;
      xfer_done_q <= timeout_fire;
    end
  end

  // The FIFO read register is the data stage: a word read in cycle N is on
  // fifo_rdata in cycle N+1, aligned with the registered beat qualifiers.
  assign wr_data   = !wr_valid_q ? '0 : (wr_pad_q ? PAD_WORD : fifo_rdata);
  assign wr_valid  = wr_valid_q;
  assign wr_last   = wr_last_q;
  assign wr_pad    = wr_pad_q;
  assign xfer_done = xfer_done_q;

  // A presented beat was issued against credit, so it is always accepted.
  sdram_addr_window #(
    .ADDR_W    (ADDR_W),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_TOP  (ADDR_TOP)
  ) u_addr_window (
    .clk        (sdram_clk),
    .rst_n      (rst_n),
    .beat       (wr_valid_q),
    .clear      (timeout_fire),
    .addr       (wr_addr),
    .wrap_pulse (wrap_pulse)
  );

endmodule
